// File: rtl/uart_tx.sv
// UART transmit core: start bit, DATA_WIDTH data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  main_clk_i,
  input  logic                  main_rst_i,
  input  logic                  ctrl_ena_i,
  output logic                  ctrl_busy_o,
  input  logic                  tx_valid_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic                  tx_ready_o,
  output logic                  txd_o
);

  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q;
  logic [BAUD_W-1:0]       baud_q;
  logic [BIT_W-1:0]        bit_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic                    txd_q;
  logic                    busy_q;
  logic                    bit_end;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q;
`endif

  assign bit_end     = (baud_q == BAUD_LAST);
  assign tx_ready_o  = (state_q == S_IDLE) & ctrl_ena_i;
  assign ctrl_busy_o = busy_q;
  assign txd_o       = txd_q;

  // Frame sequencer; txd is loaded on each transition so the line changes with the state.
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (state_q != S_IDLE) begin
        baud_q <= bit_end ? '0 : baud_q + BAUD_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (tx_valid_i && tx_ready_o) begin
            shreg_q  <= tx_data_i;
            state_q  <= S_START;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^tx_data_i;
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            txd_q   <= shreg_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg_q <= shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= parity_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              txd_q <= shreg_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
